uart_tx_8e1: RTL and testbench

Serialises bytes from FPGA logic onto a UART TX line: 8 data bits LSB first, even parity, 1 stop bit, 9600 baud from the 50 MHz board clock. It is the transmit-side counterpart of the team's 8E1 receiver and serves as its traffic source in loopback tests. A single-entry holding register lets a producer queue the next byte while the current frame is on the wire, so frames go out back-to-back with no idle gap.

---
 rtl/uart_pkg.sv | 33 +++
 rtl/uart_baud_tick.sv | 44 ++++
 rtl/uart_tx_8e1.sv | 172 +++++++++++++++++
 tb/tb_uart_tx_8e1.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the 8E1 UART transmitter and receiver:
//   - line-rate constants for the 50 MHz board clock at 9600 baud
//   - frame format constants (8 data bits, even parity, 1 stop bit)
//   - TX state encoding
//   - even-parity helper used by both directions
// ---------------------------------------------------------------------------
package uart_pkg;

  localparam int UART_CLK_FREQ = 50000000;
  localparam int UART_BAUD     = 9600;
  // Truncating division: 5208 clocks per bit, about 9600.6 baud on the wire.
  localparam int UART_BAUD_DIV = UART_CLK_FREQ / UART_BAUD;

  localparam int   DATA_BITS   = 8;
  localparam logic PARITY_EVEN = 1'b1;
  localparam int   STOP_BITS   = 1;

  typedef logic [2:0] tx_state_t;

  localparam tx_state_t TX_IDLE   = 3'd0;
  localparam tx_state_t TX_START  = 3'd1;
  localparam tx_state_t TX_DATA   = 3'd2;
  localparam tx_state_t TX_PARITY = 3'd3;
  localparam tx_state_t TX_STOP   = 3'd4;

  // Parity bit that makes the total number of ones (data + parity) even.
  function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// ---------------------------------------------------------------------------
// uart_baud_tick
// Restartable bit-period divider. Emits a one-cycle strobe on the last clock
// of every BAUD_DIV-clock period. Holding i_clear keeps the count at zero so
// the first period after release is a full BAUD_DIV clocks long.
//
// Ports:
//   CLK50MHz  in   system clock
//   RESET     in   asynchronous active-low reset
//   i_clear   in   hold counter at 0 and suppress the strobe
//   o_tick    out  1 on the final clock of each bit period
// ---------------------------------------------------------------------------
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int BAUD_DIV = UART_BAUD_DIV
) (
  input  logic CLK50MHz,
  input  logic RESET,
  input  logic i_clear,
  output logic o_tick
);

  localparam int CNT_W = $clog2(BAUD_DIV);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BAUD_DIV - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_last;

  assign w_last = (r_cnt == LAST);
  assign o_tick = w_last & ~i_clear;

  // Count 0..BAUD_DIV-1 and wrap; never passes LAST.
  always_ff @(posedge CLK50MHz or negedge RESET) begin
    if (!RESET) begin
      r_cnt <= '0;
    end else if (i_clear || w_last) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_8e1.sv
// ---------------------------------------------------------------------------
// uart_tx_8e1
// UART transmitter, 8 data bits LSB first, even parity, 1 stop bit.
// A single-entry holding register lets the producer queue the next byte while
// the current frame is shifting, so consecutive frames run with no idle gap.
//
// Ports:
//   CLK50MHz  in   system clock (50 MHz)
//   RESET     in   asynchronous active-low reset
//   DATA_IN   in   byte to send, bit 0 goes out first
//   SEND      in   producer valid, accepted on an edge where READY=1
//   READY     out  holding register empty (registered)
//   BUSY      out  frame in progress or byte held (registered)
//   TX        out  serial line, idle high (registered)
// ---------------------------------------------------------------------------
module uart_tx_8e1
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = UART_CLK_FREQ,
  parameter int BAUD     = UART_BAUD,
  parameter int BAUD_DIV = CLK_FREQ / BAUD
) (
  input  logic                 CLK50MHz,
  input  logic                 RESET,
  input  logic [DATA_BITS-1:0] DATA_IN,
  input  logic                 SEND,
  output logic                 READY,
  output logic                 BUSY,
  output logic                 TX
);

  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  tx_state_t            r_state;
  logic [2:0]           r_bit_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_parity;
  logic [DATA_BITS-1:0] r_hold;
  logic                 r_hold_valid;
  logic                 r_tx;
  logic                 r_ready;
  logic                 r_busy;

  tx_state_t            w_state_nxt;
  logic [2:0]           w_idx_nxt;
  logic [DATA_BITS-1:0] w_shift_nxt;
  logic                 w_par_nxt;
  logic                 w_hold_valid_nxt;
  logic                 w_tx_nxt;
  logic                 w_load;
  logic                 w_accept;
  logic                 w_tick;

  assign READY = r_ready;
  assign BUSY  = r_busy;
  assign TX    = r_tx;

  // READY is registered as !hold_valid, so an accept can never land on a
  // full holding register and never coincides with a shifter load.
  assign w_accept = SEND & r_ready;

  // Divider is held at zero while idle, so START gets a full bit period.
  uart_baud_tick #(
    .BAUD_DIV (BAUD_DIV)
  ) u_baud (
    .CLK50MHz (CLK50MHz),
    .RESET    (RESET),
    .i_clear  (r_state == TX_IDLE),
    .o_tick   (w_tick)
  );

  always_comb begin
    w_state_nxt      = r_state;
    w_idx_nxt        = r_bit_idx;
    w_shift_nxt      = r_shift;
    w_par_nxt        = r_parity;
    w_hold_valid_nxt = r_hold_valid;
    w_load           = 1'b0;
    w_tx_nxt         = 1'b1;

    case (r_state)
      TX_IDLE: begin
        if (r_hold_valid) begin
          w_load      = 1'b1;
          w_state_nxt = TX_START;
        end
      end
      TX_START: begin
        if (w_tick) begin
          w_state_nxt = TX_DATA;
          w_idx_nxt   = 3'd0;
        end
      end
      TX_DATA: begin
        if (w_tick) begin
          w_shift_nxt = {1'b0, r_shift[DATA_BITS-1:1]};
          if (r_bit_idx == LAST_BIT) begin
            w_state_nxt = TX_PARITY;
          end else begin
            w_idx_nxt = r_bit_idx + 3'd1;
          end
        end
      end
      TX_PARITY: begin
        if (w_tick) begin
          w_state_nxt = TX_STOP;
        end
      end
      TX_STOP: begin
        if (w_tick) begin
          if (r_hold_valid) begin
            w_load      = 1'b1;
            w_state_nxt = TX_START;
          end else begin
            w_state_nxt = TX_IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = TX_IDLE;
      end
    endcase

    if (w_load) begin
      w_shift_nxt      = r_hold;
      w_par_nxt        = even_parity(r_hold);
      w_hold_valid_nxt = 1'b0;
      w_idx_nxt        = 3'd0;
    end

    if (w_accept) begin
      w_hold_valid_nxt = 1'b1;
    end

    // TX is registered from the next state so the line has no input path.
    case (w_state_nxt)
      TX_START:  w_tx_nxt = 1'b0;
      TX_DATA:   w_tx_nxt = w_shift_nxt[0];
      TX_PARITY: w_tx_nxt = w_par_nxt;
      default:   w_tx_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge CLK50MHz or negedge RESET) begin
    if (!RESET) begin
      r_state      <= TX_IDLE;
      r_bit_idx    <= 3'd0;
      r_hold_valid <= 1'b0;
      r_tx         <= 1'b1;
      r_ready      <= 1'b1;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_bit_idx    <= w_idx_nxt;
      r_hold_valid <= w_hold_valid_nxt;
      r_tx         <= w_tx_nxt;
      r_ready      <= ~w_hold_valid_nxt;
      r_busy       <= (w_state_nxt != TX_IDLE) | w_hold_valid_nxt;
    end
  end

  // Data path registers carry no reset; they are only read when the
  // control state marks them valid.
  always_ff @(posedge CLK50MHz) begin
    r_shift  <= w_shift_nxt;
    r_parity <= w_par_nxt;
    if (w_accept) begin
      r_hold <= DATA_IN;
    end
  end

endmodule

// File: tb/tb_uart_tx_8e1.sv
module tb_uart_tx_8e1;

  localparam int BD = 16;

  logic       CLK50MHz = 1'b0;
  logic       RESET    = 1'b0;
  logic       SEND     = 1'b0;
  logic [7:0] DATA_IN  = 8'h00;
  logic       READY;
  logic       BUSY;
  logic       TX;

  int n_cmp = 0;
  int n_bad = 0;

  uart_tx_8e1 #(
    .CLK_FREQ (160),
    .BAUD     (10),
    .BAUD_DIV (BD)
  ) dut (
    .CLK50MHz (CLK50MHz),
    .RESET    (RESET),
    .DATA_IN  (DATA_IN),
    .SEND     (SEND),
    .READY    (READY),
    .BUSY     (BUSY),
    .TX       (TX)
  );

  always #10 CLK50MHz = ~CLK50MHz;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge CLK50MHz);
    #1;
  endtask

  // Sample TX at the middle of each of the 11 bit periods. Called 'elapsed'
  // edges after the edge that entered START; returns at offset BD/2+10*BD.
  task automatic rx_frame(input int elapsed, output logic [10:0] f);
    step(BD/2 - elapsed);
    for (int i = 0; i < 11; i++) begin
      f[i] = TX;
      if (i < 10) step(BD);
    end
  endtask

  task automatic chk_frame(input string tag, input logic [7:0] b, input logic par,
                           input int elapsed);
    logic [10:0] f;
    rx_frame(elapsed, f);
    chk({tag, ".start"},  f[0],   1'b0);
    chk({tag, ".data"},   f[8:1], b);
    chk({tag, ".parity"}, f[9],   par);
    chk({tag, ".stop"},   f[10],  1'b1);
  endtask

  // Pulse SEND for one edge; returns just after the accept edge.
  task automatic send_pulse(input logic [7:0] b);
    SEND    = 1'b1;
    DATA_IN = b;
    step(1);
    SEND    = 1'b0;
    DATA_IN = 8'h00;
  endtask

  task automatic single_frame(input string tag, input logic [7:0] b, input logic par);
    send_pulse(b);
    chk({tag, ".ready_acc"}, READY, 1'b0);
    chk({tag, ".busy_acc"},  BUSY,  1'b1);
    chk({tag, ".tx_acc"},    TX,    1'b1);
    step(1);
    chk({tag, ".tx_start"},  TX,    1'b0);
    chk({tag, ".ready_ld"},  READY, 1'b1);
    chk_frame(tag, b, par, 0);
    step(BD/2 - 1);
    chk({tag, ".busy_last"}, BUSY,  1'b1);
    chk({tag, ".tx_last"},   TX,    1'b1);
    step(1);
    chk({tag, ".busy_end"},  BUSY,  1'b0);
    chk({tag, ".tx_end"},    TX,    1'b1);
  endtask

  initial begin
    logic [10:0] f;
    logic [7:0]  lb [4];
    int          t;

    // Reset state
    step(2);
    chk("rst.tx",    TX,    1'b1);
    chk("rst.ready", READY, 1'b1);
    chk("rst.busy",  BUSY,  1'b0);
    RESET = 1'b1;
    step(3);
    chk("idle.tx",   TX,    1'b1);
    chk("idle.busy", BUSY,  1'b0);

    // Single frames: 0xA5 has four ones, 0x07 has three
    single_frame("a5", 8'hA5, 1'b0);
    step(3);
    single_frame("07", 8'h07, 1'b1);
    step(3);

    // Back-to-back 0x55 then 0xAA, second byte queued as soon as READY rises
    send_pulse(8'h55);
    step(1);
    chk("b2b.ready1", READY, 1'b1);
    SEND    = 1'b1;
    DATA_IN = 8'hAA;
    step(1);
    SEND    = 1'b0;
    chk("b2b.ready_held", READY, 1'b0);
    chk_frame("b2b55", 8'h55, 1'b0, 1);
    step(BD/2 - 1);
    chk("b2b.stop_last", TX, 1'b1);
    step(1);
    chk("b2b.start2",  TX,    1'b0);
    chk("b2b.busy2",   BUSY,  1'b1);
    chk("b2b.ready2",  READY, 1'b1);
    chk_frame("b2bAA", 8'hAA, 1'b0, 0);
    step(BD/2);
    chk("b2b.busy_end", BUSY, 1'b0);
    step(3);

    // SEND held high with changing data: only accept-edge bytes go out
    SEND    = 1'b1;
    DATA_IN = 8'h12;
    step(1);
    DATA_IN = 8'h34;
    step(1);
    chk("hold.ready_ld", READY, 1'b1);
    step(1);
    chk("hold.ready_acc", READY, 1'b0);
    DATA_IN = 8'hEE;
    step(1);
    DATA_IN = 8'hDD;
    step(1);
    DATA_IN = 8'hC3;
    step(1);
    SEND    = 1'b0;
    chk("hold.ready_full", READY, 1'b0);
    chk_frame("hold12", 8'h12, 1'b0, 4);
    step(BD/2);
    chk("hold.start2", TX, 1'b0);
    chk_frame("hold34", 8'h34, 1'b1, 0);
    step(BD/2);
    chk("hold.busy_end", BUSY, 1'b0);
    step(3);

    // Reset in the middle of data bit 4 of 0x3C, with 0x99 held
    send_pulse(8'h3C);
    step(1);
    SEND    = 1'b1;
    DATA_IN = 8'h99;
    step(1);
    SEND    = 1'b0;
    step(BD/2 - 1);
    step(5*BD);
    chk("rst_mid.bit4", TX, 1'b1);
    chk("rst_mid.busy_pre", BUSY, 1'b1);
    #3;
    RESET = 1'b0;
    #1;
    chk("rst_mid.tx",    TX,    1'b1);
    chk("rst_mid.ready", READY, 1'b1);
    chk("rst_mid.busy",  BUSY,  1'b0);
    step(1);
    RESET = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(BD);
      chk("rst_mid.idle_tx",   TX,   1'b1);
      chk("rst_mid.idle_busy", BUSY, 1'b0);
    end

    // Loopback through a bench-side 8E1 receiver
    lb[0] = 8'h00;
    lb[1] = 8'hFF;
    lb[2] = 8'h81;
    lb[3] = 8'h7E;
    for (int k = 0; k < 4; k++) begin
      send_pulse(lb[k]);
      t = 0;
      while (TX !== 1'b0 && t < 4*BD) begin
        step(1);
        t++;
      end
      if (t >= 4*BD) begin
        chk("lb.timeout", 32'(t), 32'(4*BD - 1));
      end else begin
        rx_frame(0, f);
        chk("lb.start",    f[0],    1'b0);
        chk("lb.data",     f[8:1],  lb[k]);
        chk("lb.parity_ok", ^f[9:1], 1'b0);
        chk("lb.stop",     f[10],   1'b1);
      end
      step(BD);
      chk("lb.idle", BUSY, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
